// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential parametrised ALU.
//   - op_e     : 3-bit opcode encoding (OP_ADD .. OP_SHR)
//   - state_e  : control FSM states of alu_seq_param
//   - FLG_*    : bit positions inside the {ovf,neg,zero} flags vector
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int FLAGS_W  = 3;
    localparam int FLG_ZERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_OVF  = 2;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears the step counter only)
//   start          load a/b and begin a W-step multiplication
//   a, b           W-bit unsigned operands (a is the multiplier scanned LSB first)
//   busy           steps remain
//   done           the current edge performs the final step
//   p              2W-bit product; equals a*b while done is high
module alu_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, mcand_q, acc_step;
    logic [W-1:0]   mplier_q;

    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CW'(1));
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The final step's sum is presented directly so the owner can capture the
    // product on the same edge that retires the last step.
    assign p        = acc_step;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(W);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Datapath registers carry no reset: they are only observed while busy.
    always_ff @(posedge clk) begin
        if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, b};
            mplier_q <= a;
        end else if (busy) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: handshaked W-bit ALU with registered 2W-bit result and an
// iterative multiplier. One operation in flight at a time.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready does not depend on in_valid
//   op, a, b             opcode (alu_seq_pkg::op_e) and unsigned operands
//   out_valid/out_ready  result handshake; outputs hold while stalled
//   result               2W-bit registered result
//   cout                 carry (ADD) / no-borrow (SUB), 0 for other ops
//   flags                {ovf,neg,zero}; present only when ALU_SEQ_FLAGS_EN is defined
// Configuration macro: ALU_SEQ_FLAGS_EN (undefined by default: no flags port or logic).
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           cout
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic [FLAGS_W-1:0] flags
`endif
);

    localparam int SHW = $clog2(W);

    state_e         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [2*W-1:0] result_q, result_d;
    logic           cout_q, cout_d;

    op_e            op_w;
    logic           accept, mul_start, mul_busy, mul_done;
    logic [2*W-1:0] mul_p;
    logic [W:0]     sum_w, diff_w;
    logic [2*W-1:0] alu_res;
    logic           alu_cout;

    assign op_w = op_e'(op);

    // mul_busy is implied by ST_MUL; gating on it as well keeps a new
    // operation from ever being accepted while the engine is still stepping.
    assign in_ready  = (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_w == OP_MUL);

    // SUB is a + ~b + 1, so the carry out reads as "no borrow".
    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (op_w)
            OP_ADD: begin
                alu_res  = {{W{1'b0}}, sum_w[W-1:0]};
                alu_cout = sum_w[W];
            end
            OP_SUB: begin
                alu_res  = {{W{1'b0}}, diff_w[W-1:0]};
                alu_cout = diff_w[W];
            end
            OP_AND:  alu_res = {{W{1'b0}}, a & b};
            OP_OR:   alu_res = {{W{1'b0}}, a | b};
            OP_XOR:  alu_res = {{W{1'b0}}, a ^ b};
            OP_SHL:  alu_res = {{W{1'b0}}, a} << b[SHW-1:0];
            OP_SHR:  alu_res = {{W{1'b0}}, a >> b[SHW-1:0]};
            default: alu_res = '0;
        endcase
    end

    alu_seq_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

`ifdef ALU_SEQ_FLAGS_EN
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               alu_ovf;
    logic [FLAGS_W-1:0] alu_flags, mul_flags;

    // Signed overflow: ADD with like-signed operands, SUB with unlike-signed
    // operands, and the result sign differs from a.
    assign alu_ovf = (op_w == OP_ADD) ? ((a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1])) :
                     (op_w == OP_SUB) ? ((a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1])) :
                     1'b0;

    function automatic logic [FLAGS_W-1:0] make_flags(input logic [2*W-1:0] r,
                                                      input logic           neg,
                                                      input logic           ovf);
        logic [FLAGS_W-1:0] f;
        f           = '0;
        f[FLG_ZERO] = (r == '0);
        f[FLG_NEG]  = neg;
        f[FLG_OVF]  = ovf;
        return f;
    endfunction

    assign alu_flags = make_flags(alu_res, alu_res[W-1], alu_ovf);
    assign mul_flags = make_flags(mul_p, mul_p[2*W-1], 1'b0);
    assign flags     = flags_q;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cout_d      = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
        flags_d     = flags_q;
`endif
        // Drain first; a same-edge load below overrides it for full throughput.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_w == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        cout_d      = alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
                        flags_d     = alu_flags;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_p;
                    cout_d      = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                    flags_d     = mul_flags;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed bench for alu_seq_param (W=8) with a cycle-level
// reference model of the handshake/latency rules and literal expectations.
module tb_alu_seq_param;
    import alu_seq_pkg::*;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [2:0]     op = 3'b000;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready, out_valid, cout;
    logic [2*W-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
    logic [FLAGS_W-1:0] flags;
`endif

    always #5 clk = ~clk;

    alu_seq_param #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions; returns {flags, cout, result}.
    function automatic logic [2*W+3:0] spec_eval(input logic [2:0] o, input int unsigned x,
                                                 input int unsigned y);
        int unsigned r, sh;
        int sx, sy, sr;
        logic c, ovf, neg;
        logic [2*W-1:0] rr;
        logic [FLAGS_W-1:0] f;
        sh  = y % W;
        sx  = (x >= HALF) ? int'(x) - FULL : int'(x);
        sy  = (y >= HALF) ? int'(y) - FULL : int'(y);
        r   = 0;
        c   = 1'b0;
        ovf = 1'b0;
        sr  = 0;
        case (o)
            3'd0: begin
                r = (x + y) % FULL; c = ((x + y) >= FULL);
                sr = sx + sy; ovf = (sr >= HALF) || (sr < -HALF);
            end
            3'd1: begin
                r = (x + FULL - y) % FULL; c = (x >= y);
                sr = sx - sy; ovf = (sr >= HALF) || (sr < -HALF);
            end
            3'd2: r = x * y;
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = x << sh;
            default: r = x >> sh;
        endcase
        rr  = r[2*W-1:0];
        neg = (o == 3'd2) ? rr[2*W-1] : rr[W-1];
        f = '0;
        f[FLG_ZERO] = (rr == '0);
        f[FLG_NEG]  = neg;
        f[FLG_OVF]  = ovf;
        return {f, c, rr};
    endfunction

    // ---------------- reference model ----------------
    logic               m_valid, m_cout;
    logic [2*W-1:0]     m_result, m_mulres;
    logic [FLAGS_W-1:0] m_flags, m_mulflags;
    int                 m_cnt;
    logic [2*W+3:0]     e_pack;
    logic               m_rdy;

    always_comb e_pack = spec_eval(op, 32'(a), 32'(b));
    assign m_rdy = (m_cnt == 0) && (!m_valid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_result <= '0;
            m_cout   <= 1'b0;
            m_flags  <= '0;
            m_cnt    <= 0;
        end else begin
            if (m_valid && out_ready) m_valid <= 1'b0;
            if (m_cnt > 0) begin
                if (m_cnt == 1) begin
                    m_valid  <= 1'b1;
                    m_result <= m_mulres;
                    m_cout   <= 1'b0;
                    m_flags  <= m_mulflags;
                end
                m_cnt <= m_cnt - 1;
            end else if (in_valid && m_rdy) begin
                if (op == 3'b010) begin
                    m_cnt      <= W;
                    m_mulres   <= e_pack[2*W-1:0];
                    m_mulflags <= e_pack[2*W+3:2*W+1];
                end else begin
                    m_valid  <= 1'b1;
                    m_result <= e_pack[2*W-1:0];
                    m_cout   <= e_pack[2*W];
                    m_flags  <= e_pack[2*W+3:2*W+1];
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cyc_in_ready", in_ready, m_rdy);
            check("cyc_out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("cyc_result", result, m_result);
                check("cyc_cout", cout, m_cout);
`ifdef ALU_SEQ_FLAGS_EN
                check("cyc_flags", flags, m_flags);
`endif
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        op = o; a = x; b = y; in_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_timeout", 64'(k < 50), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int rdy_hi);
        lat = 0; rdy_hi = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        check("result_timeout", 64'(lat < 40), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", out_valid, 1'b0);
    endtask

    typedef struct {
        logic [2:0]     o;
        logic [W-1:0]   x, y;
        logic [2*W-1:0] r;
        logic           c;
    } vec_t;

    initial begin
        int lat, rdy_hi;
        vec_t misc[4];
        logic [W-1:0]   xa[4], xb[4];
        logic [2*W-1:0] xr[4];

        misc[0] = '{3'b110, 8'hFF, 8'h0B, 16'h07F8, 1'b0}; // SHL by 3
        misc[1] = '{3'b111, 8'hF0, 8'h04, 16'h000F, 1'b0}; // SHR by 4
        misc[2] = '{3'b011, 8'hCC, 8'hAA, 16'h0088, 1'b0}; // AND
        misc[3] = '{3'b100, 8'hC0, 8'h0A, 16'h00CA, 1'b0}; // OR
        xa = '{8'h12, 8'h3C, 8'hFF, 8'h80};
        xb = '{8'h34, 8'h3C, 8'h0F, 8'h01};
        xr = '{16'h0026, 16'h0000, 16'h00F0, 16'h0081};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_cout", cout, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst_flags", flags, 3'b000);
`endif
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // ADD 200+100
        issue(3'b000, 8'd200, 8'd100);
        wait_valid(lat, rdy_hi);
        check("add_latency", 64'(lat), 64'd0);
        check("add_result", result, 16'h002C);
        check("add_cout", cout, 1'b1);
        drain();

        // SUB both directions
        issue(3'b001, 8'd5, 8'd7);
        wait_valid(lat, rdy_hi);
        check("sub_5_7_result", result, 16'h00FE);
        check("sub_5_7_cout", cout, 1'b0);
        drain();
        issue(3'b001, 8'd7, 8'd5);
        wait_valid(lat, rdy_hi);
        check("sub_7_5_result", result, 16'h0002);
        check("sub_7_5_cout", cout, 1'b1);
        drain();

        // MUL 255*255
        issue(3'b010, 8'd255, 8'd255);
        wait_valid(lat, rdy_hi);
        check("mul_latency", 64'(lat), 64'd8);
        check("mul_in_ready_low", 64'(rdy_hi), 64'd0);
        check("mul_result", result, 16'hFE01);
        check("mul_cout", cout, 1'b0);
        drain();

        // Shifts and logic ops
        for (int i = 0; i < 4; i++) begin
            issue(misc[i].o, misc[i].x, misc[i].y);
            wait_valid(lat, rdy_hi);
            check("misc_result", result, misc[i].r);
            check("misc_cout", cout, misc[i].c);
            drain();
        end

        // Back-to-back XOR, one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 3'b101; a = xa[i]; b = xb[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_result", result, xr[i]);
        end

        // Stall: pending XOR must wait, held result stays put
        out_ready = 1'b0;
        op = 3'b101; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_result", result, 16'h0081);
            check("hold_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("unstall_result", result, 16'h0003);
        check("unstall_valid", out_valid, 1'b1);

        // Drain + accept MUL on the same edge: out_valid drops, MUL runs
        op = 3'b010; a = 8'd2; b = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("drain_mul_valid", out_valid, 1'b0);
        check("drain_mul_in_ready", in_ready, 1'b0);
        out_ready = 1'b0;
        wait_valid(lat, rdy_hi);
        check("drain_mul_latency", 64'(lat), 64'd8);
        check("drain_mul_result", result, 16'h0006);
        drain();

        // Reset in the middle of a MUL
        issue(3'b010, 8'h10, 8'h10);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        issue(3'b010, 8'd3, 8'd4);
        wait_valid(lat, rdy_hi);
        check("mul_3_4_latency", 64'(lat), 64'd8);
        check("mul_3_4_result", result, 16'h000C);
        drain();

        // Signed-overflow and zero corner cases
        issue(3'b000, 8'h7F, 8'h01);
        wait_valid(lat, rdy_hi);
        check("add_ovf_result", result, 16'h0080);
        check("add_ovf_cout", cout, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        check("add_ovf_flags", flags, 3'b110);
`endif
        drain();
        issue(3'b001, 8'd9, 8'd9);
        wait_valid(lat, rdy_hi);
        check("sub_zero_result", result, 16'h0000);
        check("sub_zero_cout", cout, 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
        check("sub_zero_flags", flags, 3'b001);
`endif
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
